spi_chain_master: RTL and testbench

- Parametrised SPI master for daisy-chained MAX7219-class shift-register slaves.
- Shifts one frame of NUM_DEV x FRAME_W bits, MSB first, under a single chip-select window; slaves latch on the cs_n rising edge.
- Runs from the system clock with a programmable SCLK divider and a valid/ready input handshake.
- Sits between the display controller (frame producer) and the board pins.

---
 rtl/spi_chain_master.sv | 149 ++++++++++++++
 tb/tb_spi_chain_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_chain_master.sv
// rtl/spi_chain_master.sv - SPI mode-0 master shifting one frame through a daisy chain of shift-register slaves
module spi_chain_master #(
  parameter int NUM_DEV = 4,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_DEV*FRAME_W-1:0]   tx_data,
  output logic                         busy,
  output logic                         done,
  output logic                         sclk,
  output logic                         mosi,
  output logic                         cs_n
);

  localparam int NB = NUM_DEV * FRAME_W;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NB + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    HOLD     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [NB-1:0]   shreg_q, shreg_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            in_ready_q, in_ready_d;
  logic            div_last;
  logic [BW-1:0]   bit_next;

  assign div_last = (div_q == DW'(CLK_DIV - 1));
  assign bit_next = bit_q + BW'(1);

  // Next-state logic; every output is derived from the next state so it is registered.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = SHIFT_LO;
          shreg_d = tx_data;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          state_d = SHIFT_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_d = '0;
          bit_d = bit_next;
          if (bit_next < BW'(NB)) begin
            // Shifting here, at the falling edge, keeps mosi stable across the whole low half.
            state_d = SHIFT_LO;
            shreg_d = {shreg_q[NB-2:0], 1'b0};
          end else begin
            state_d = HOLD;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      HOLD: begin
        if (div_last) begin
          state_d = GAP;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      GAP: begin
        if (div_last) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = '0;
      end
    endcase

    sclk_d     = (state_d == SHIFT_HI);
    cs_n_d     = !((state_d == SHIFT_LO) || (state_d == SHIFT_HI) || (state_d == HOLD));
    mosi_d     = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shreg_d[NB-1] : 1'b0;
    done_d     = (state_q == HOLD) && (state_d == GAP);
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any partial frame without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_spi_chain_master.sv
// tb/tb_spi_chain_master.sv - directed self-checking bench for spi_chain_master
module tb_spi_chain_master;

  logic        clk = 1'b0;
  logic        rst_n_a, rst_n_b;
  logic [1:0]  valid_v, ready_v, busy_v, done_v, sclk_v, mosi_v, cs_v, rst_v;
  logic [31:0] tx_a;
  logic [15:0] tx_b;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  int          nwin[2];
  logic [31:0] cap[2];
  int          rises[2], low_len[2], hi_len[2], done_cnt[2];
  int          last_rise[2], min_iv[2], max_iv[2];
  logic [31:0] cap_w[2][8];
  int          len_w[2][8], gap_w[2][8], rise_w[2][8];
  logic [1:0]  p_sclk, p_mosi, p_cs;

  always #5 clk = ~clk;

  assign rst_v = {rst_n_b, rst_n_a};

  spi_chain_master #(.NUM_DEV(2), .FRAME_W(16), .CLK_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_valid(valid_v[0]), .in_ready(ready_v[0]),
    .tx_data(tx_a), .busy(busy_v[0]), .done(done_v[0]), .sclk(sclk_v[0]),
    .mosi(mosi_v[0]), .cs_n(cs_v[0])
  );

  spi_chain_master #(.NUM_DEV(1), .FRAME_W(16), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_valid(valid_v[1]), .in_ready(ready_v[1]),
    .tx_data(tx_b), .busy(busy_v[1]), .done(done_v[1]), .sclk(sclk_v[1]),
    .mosi(mosi_v[1]), .cs_n(cs_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: window capture and protocol rules, sampled on the falling clock edge.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst_v[d]) begin
        if (p_sclk[d] && sclk_v[d]) chk("mosi_stable_hi", mosi_v[d], p_mosi[d]);
        if (p_cs[d] && cs_v[d])     chk("sclk_still_cs_hi", sclk_v[d], p_sclk[d]);
        chk("done_at_cs_rise", done_v[d], !p_cs[d] && cs_v[d]);
      end
      if (done_v[d]) done_cnt[d]++;
      if (!cs_v[d]) begin
        if (p_cs[d]) begin
          if (nwin[d] < 8) gap_w[d][nwin[d]] = hi_len[d];
          low_len[d] = 0; cap[d] = '0; rises[d] = 0; min_iv[d] = 999; max_iv[d] = 0;
        end
        low_len[d]++;
      end else begin
        if (!p_cs[d]) begin
          if (nwin[d] < 8) begin
            cap_w[d][nwin[d]]  = cap[d];
            len_w[d][nwin[d]]  = low_len[d];
            rise_w[d][nwin[d]] = rises[d];
          end
          nwin[d]++;
          hi_len[d] = 0;
        end
        hi_len[d]++;
      end
      if (!p_sclk[d] && sclk_v[d]) begin
        cap[d] = {cap[d][30:0], mosi_v[d]};
        if (rises[d] > 0) begin
          if (cyc - last_rise[d] < min_iv[d]) min_iv[d] = cyc - last_rise[d];
          if (cyc - last_rise[d] > max_iv[d]) max_iv[d] = cyc - last_rise[d];
        end
        last_rise[d] = cyc;
        rises[d]++;
      end
      p_sclk[d] = sclk_v[d];
      p_mosi[d] = mosi_v[d];
      p_cs[d]   = cs_v[d];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear(input int d);
    nwin[d] = 0;
    done_cnt[d] = 0;
  endtask

  task automatic send_a(input logic [31:0] data);
    valid_v[0] = 1'b1; tx_a = data;
    step();
    valid_v[0] = 1'b0; tx_a = '0;
  endtask

  task automatic wait_done(input int d, input int n);
    for (int i = 0; i < 3000 && done_cnt[d] < n; i++) step();
    chk("done_within_budget", 32'(done_cnt[d] >= n), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      nwin[d] = 0; done_cnt[d] = 0; cap[d] = '0; rises[d] = 0; low_len[d] = 0;
      hi_len[d] = 0; last_rise[d] = 0; min_iv[d] = 999; max_iv[d] = 0;
    end
    p_sclk = '0; p_mosi = '0; p_cs = '1;
    rst_n_a = 1'b0; rst_n_b = 1'b0; valid_v = '0; tx_a = '0; tx_b = '0;
    step(); step(); step();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    step();

    chk("rst_sclk", sclk_v[0], 1'b0);
    chk("rst_mosi", mosi_v[0], 1'b0);
    chk("rst_cs_n", cs_v[0], 1'b1);
    chk("rst_done", done_v[0], 1'b0);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_in_ready", ready_v[0], 1'b1);

    // Single 32-bit frame across two devices.
    clear(0);
    send_a(32'h0C01_0A0F);
    chk("t1_cs_low", cs_v[0], 1'b0);
    chk("t1_busy", busy_v[0], 1'b1);
    chk("t1_in_ready", ready_v[0], 1'b0);
    chk("t1_mosi_msb", mosi_v[0], 1'b0);
    wait_done(0, 1);
    chk("t1_ready_at_done", ready_v[0], 1'b0);
    chk("t1_cs_at_done", cs_v[0], 1'b1);
    chk("t1_win", nwin[0], 1);
    chk("t1_len", len_w[0][0], 130);
    chk("t1_rises", rise_w[0][0], 32);
    chk("t1_cap", cap_w[0][0], 32'h0C01_0A0F);
    step();
    chk("t1_ready_plus1", ready_v[0], 1'b0);
    chk("t1_done_plus1", done_v[0], 1'b0);
    step();
    chk("t1_ready_plus2", ready_v[0], 1'b1);
    chk("t1_busy_plus2", busy_v[0], 1'b0);

    // Back-to-back frames with in_valid held high.
    clear(0);
    valid_v[0] = 1'b1; tx_a = 32'h0900_0000;
    step();
    tx_a = 32'h0B07_0F0F;
    for (int i = 0; i < 3000 && !ready_v[0]; i++) step();
    chk("t2_ready_seen", ready_v[0], 1'b1);
    step();
    valid_v[0] = 1'b0;
    wait_done(0, 2);
    for (int i = 0; i < 8; i++) step();
    chk("t2_win", nwin[0], 2);
    chk("t2_cap0", cap_w[0][0], 32'h0900_0000);
    chk("t2_cap1", cap_w[0][1], 32'h0B07_0F0F);
    chk("t2_len1", len_w[0][1], 130);
    chk("t2_gap", gap_w[0][1], 3);
    chk("t2_dones", done_cnt[0], 2);

    // in_valid while busy is ignored.
    clear(0);
    send_a(32'h1234_5678);
    for (int i = 0; i < 20; i++) step();
    valid_v[0] = 1'b1; tx_a = 32'hFFFF_FFFF;
    step();
    valid_v[0] = 1'b0; tx_a = '0;
    wait_done(0, 1);
    for (int i = 0; i < 12; i++) step();
    chk("t3_win", nwin[0], 1);
    chk("t3_cap", cap_w[0][0], 32'h1234_5678);
    chk("t3_dones", done_cnt[0], 1);
    chk("t3_idle_ready", ready_v[0], 1'b1);

    // Reset mid-transfer at bit 10.
    clear(0);
    send_a(32'hDEAD_BEEF);
    for (int i = 0; i < 3000 && rises[0] < 10; i++) step();
    chk("t4_at_bit10", rises[0], 10);
    rst_n_a = 1'b0;
    #1;
    chk("t4_cs_n", cs_v[0], 1'b1);
    chk("t4_sclk", sclk_v[0], 1'b0);
    chk("t4_mosi", mosi_v[0], 1'b0);
    chk("t4_busy", busy_v[0], 1'b0);
    chk("t4_in_ready", ready_v[0], 1'b1);
    step(); step();
    chk("t4_no_done", done_cnt[0], 0);
    rst_n_a = 1'b1;
    step();
    clear(0);
    send_a(32'hC3A5_5A3C);
    wait_done(0, 1);
    chk("t4_cap", cap_w[0][0], 32'hC3A5_5A3C);
    chk("t4_rises", rise_w[0][0], 32);
    chk("t4_len", len_w[0][0], 130);

    // Single device, fastest divider.
    clear(1);
    valid_v[1] = 1'b1; tx_b = 16'hA5C3;
    step();
    valid_v[1] = 1'b0; tx_b = '0;
    wait_done(1, 1);
    chk("t5_cap", cap_w[1][0], 32'h0000_A5C3);
    chk("t5_len", len_w[1][0], 33);
    chk("t5_rises", rise_w[1][0], 16);
    chk("t5_min_period", min_iv[1], 2);
    chk("t5_max_period", max_iv[1], 2);
    step(); step();
    chk("t5_ready", ready_v[1], 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
